// File: rtl/branch_comparator_pipe_if.sv
// Operand/result handshake bundle for branch_comparator_pipe.
// The producer (master) drives the operands and out_ready. The comparator (slave) drives the results.
interface branch_comparator_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             igual;
  logic             menor_s;
  logic             menor_u;
  logic             illegal;

  modport master (
    output in_valid, A, B, funct3, out_ready,
    input  in_ready, out_valid, taken, igual, menor_s, menor_u, illegal
  );

  modport slave (
    input  in_valid, A, B, funct3, out_ready,
    output in_ready, out_valid, taken, igual, menor_s, menor_u, illegal
  );
endinterface

// File: rtl/branch_comparator_pipe.sv
// Registered RISC-V branch-condition evaluator with a one-entry valid/ready output stage.
// Optional delivery statistics are enabled by defining COMPARATOR_STATS_EN.
module branch_comparator_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      stats_clr,
  branch_comparator_pipe_if.slave   bus,
  output logic [CNT_W-1:0]          total_cnt,
  output logic [CNT_W-1:0]          taken_cnt
);

  logic             out_valid_q;
  logic             taken_q, igual_q, menor_s_q, menor_u_q, illegal_q;
  logic             accept;
  logic             igual_c, menor_s_c, menor_u_c, taken_c, illegal_c;
  logic [WIDTH-1:0] a_op, b_op;

  assign a_op        = bus.A;
  assign b_op        = bus.B;
  assign bus.in_ready = !flush && (!out_valid_q || bus.out_ready);
  assign accept      = bus.in_valid && bus.in_ready;

  assign igual_c   = (a_op == b_op);
  assign menor_s_c = ($signed(a_op) < $signed(b_op));
  assign menor_u_c = (a_op < b_op);

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (bus.funct3)
      3'b000:  taken_c = igual_c;
      3'b001:  taken_c = !igual_c;
      3'b100:  taken_c = menor_s_c;
      3'b101:  taken_c = !menor_s_c;
      3'b110:  taken_c = menor_u_c;
      3'b111:  taken_c = !menor_u_c;
      default: illegal_c = 1'b1;
    endcase
  end

  // Flags only load on accept; they may go stale while out_valid_q is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      igual_q     <= 1'b0;
      menor_s_q   <= 1'b0;
      menor_u_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      taken_q     <= taken_c;
      igual_q     <= igual_c;
      menor_s_q   <= menor_s_c;
      menor_u_q   <= menor_u_c;
      illegal_q   <= illegal_c;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.taken     = taken_q;
  assign bus.igual     = igual_q;
  assign bus.menor_s   = menor_s_q;
  assign bus.menor_u   = menor_u_q;
  assign bus.illegal   = illegal_q;

`ifdef COMPARATOR_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             deliver;
  logic [CNT_W-1:0] total_cnt_q, taken_cnt_q;

  assign deliver = out_valid_q && bus.out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else if (stats_clr) begin
      total_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else if (deliver) begin
      if (total_cnt_q != CntMax) total_cnt_q <= total_cnt_q + 1'b1;
      if (taken_q && (taken_cnt_q != CntMax)) taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign total_cnt = total_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign total_cnt        = '0;
  assign taken_cnt        = '0;
`endif

endmodule
